tx: RTL and testbench
=====================

TX -- requirements
Module: tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417, meaning clk cycles per serial bit (100 MHz clk, 9600 baud).
REQ-002 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 The block SHALL have port tx_en  input  1  transmitter enable; gates acceptance of new frames.
REQ-005 The block SHALL have port data_in  input  8  parallel byte to send.
REQ-006 The block SHALL have port data_valid  input  1  data_in holds a byte to send.
REQ-007 The block SHALL have port data_ready  output  1  block can accept a byte this cycle.
REQ-008 The block SHALL have port data_out  output  1  serial line, idle high.
REQ-009 The block SHALL have port busy  output  1  a frame is on the line.

Function
REQ-010 A byte SHALL be accepted on a rising edge where tx_en, data_valid and data_ready are all 1; data_in is latched then.
REQ-011 data_ready SHALL be 1 only in IDLE; it drops the cycle after acceptance.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-013 IDLE->START on acceptance; START->DATA, DATA->PARITY/STOP after bit 7, PARITY->STOP, STOP->IDLE; each transition occurs after exactly CLKS_PER_BIT cycles in the bit.
REQ-014 data_out SHALL be 0 in START, the latched bit in DATA (LSB first, bit 0..7), 1 in STOP and IDLE.
REQ-015 The start bit SHALL appear on data_out one cycle after the acceptance edge (latency 1).
REQ-016 Each bit SHALL last exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles (11* with parity).
REQ-017 busy SHALL be 1 from START through the last cycle of STOP, else 0.
REQ-018 The bit-period counter SHALL count 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT), and wrap to 0 at each bit boundary.
REQ-019 The bit index counter SHALL be 3 bits, 0..7, no wrap outside DATA.
REQ-020 data_valid while busy SHALL be ignored; the latched byte SHALL NOT change mid-frame.
REQ-021 tx_en deasserting mid-frame SHALL NOT abort the frame; it only blocks the next acceptance.
REQ-022 Back-to-back: data_valid held high with tx_en SHALL give a new start bit one cycle after the STOP bit ends (one IDLE cycle at line high).

Reset
REQ-023 On rst=1 at a rising edge: state IDLE, data_out=1, busy=0, data_ready=0 while rst high, counters 0, latched byte 0.
REQ-024 Reset mid-frame SHALL abort immediately; data_out=1 from the next edge; data_ready=1 the first cycle after rst falls.

Configuration
REQ-025 Macro TX_PARITY_EN defined: PARITY state inserted after DATA, driving even parity (XOR of the 8 bits) for CLKS_PER_BIT cycles.
REQ-026 Macro TX_PARITY_EN undefined: no PARITY state, no parity logic, frame 8N1.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state typedef, the default CLKS_PER_BIT constant and the frame-length constants, for reuse by rx.
REQ-028 The bit-period counter SHALL be a sub-module baud_gen emitting a one-cycle bit_tick, cleared on frame start.

Verification
REQ-029 Send 0xA5 with tx_en=1 -> line 0,1,0,1,0,0,1,0,1,1, each bit 10417 cycles, busy high 104170 cycles.
REQ-030 Send 0xFF then 0x00 back-to-back -> second start bit exactly one cycle after first stop ends; data_ready pulses once per byte.
REQ-031 data_valid=1 with tx_en=0 for 50000 cycles -> data_out stays 1, busy 0, no acceptance.
REQ-032 rst=1 at cycle 30000 of a frame of 0x3C -> data_out=1 and busy=0 next cycle; following 0x81 sent correctly.
REQ-033 TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame 11 bits (114587 cycles); send 0x03 -> parity bit 0.
REQ-034 Change data_in and drop tx_en mid-frame of 0x5A -> transmitted bits still 0x5A, frame completes.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions used by tx (and rx).
//
// Contents:
//   DEFAULT_CLKS_PER_BIT  clk cycles per serial bit (100 MHz clk, 9600 baud)
//   DATA_BITS             payload bits per frame
//   FRAME_BITS_8N1        start + 8 data + stop
//   FRAME_BITS_8E1        start + 8 data + even parity + stop
//   uart_state_t, ST_*    frame FSM state encoding
//   even_parity()         XOR reduction of a payload byte
//
// The parity state constant always exists here so that rx and tx share one
// encoding; whether a block ever enters it is decided by TX_PARITY_EN in
// that block.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;
  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS_8N1       = 10;
  localparam int FRAME_BITS_8E1       = 11;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// baud_gen -- bit-period counter for the UART transmitter.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   clr       in   restart the bit period (frame start)
//   en        in   count while a frame is on the line
//   bit_tick  out  one-cycle pulse in the last cycle of each bit period
//
// The counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on the tick, so the
// consumer advances its state on exactly the edge where the tick is high.
module baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  // A one-cycle bit period still needs a 1-bit counter to hold the type legal.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tx.sv
// tx -- UART transmitter, 8N1 (8E1 when TX_PARITY_EN is defined).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   tx_en       in   transmitter enable, gates acceptance of new bytes
//   data_in     in   byte to send
//   data_valid  in   data_in holds a byte to send
//   data_ready  out  a byte can be accepted this cycle (IDLE, not in reset)
//   data_out    out  serial line, idle high
//   busy        out  a frame is on the line
//
// Configuration macro:
//   TX_PARITY_EN  insert an even-parity bit between bit 7 and the stop bit.
//
// data_out and busy are registered from the next-state decode so the line
// changes cleanly on the clock edge; the start bit therefore appears on the
// line directly after the acceptance edge.
module tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       data_out,
  output logic       busy
);

  uart_state_t            state;
  uart_state_t            state_nxt;
  logic [2:0]             bit_idx;
  logic [2:0]             bit_idx_nxt;
  logic [DATA_BITS-1:0]   data_q;
  logic                   line_nxt;
  logic                   accept;
  logic                   bit_tick;

  // Ready is held low for as long as rst is asserted, and rises as soon as
  // rst falls because the state is already IDLE by then.
  assign data_ready = (state == ST_IDLE) && !rst;
  assign accept     = tx_en && data_valid && data_ready;

  baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (state != ST_IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt   = ST_START;
          bit_idx_nxt = 3'd0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
            // Leave the index parked at 0 outside DATA instead of wrapping.
            bit_idx_nxt = 3'd0;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        bit_idx_nxt = 3'd0;
      end
    endcase
  end

  // Line level for the cycle after this edge; data_q is already latched by
  // the time DATA is entered, since acceptance happens one full bit earlier.
  always_comb begin
    line_nxt = 1'b1;
    case (state_nxt)
      ST_START:  line_nxt = 1'b0;
      ST_DATA:   line_nxt = data_q[bit_idx_nxt];
`ifdef TX_PARITY_EN
      ST_PARITY: line_nxt = even_parity(data_q);
`endif
      default:   line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_idx  <= 3'd0;
      data_out <= 1'b1;
      busy     <= 1'b0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      bit_idx  <= bit_idx_nxt;
      data_out <= line_nxt;
      busy     <= (state_nxt != ST_IDLE);
      // Only the acceptance edge loads the byte, so data_in is free to move
      // for the rest of the frame.
      if (accept) begin
        data_q <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_tx.sv
// tb_tx -- self-checking bench for the UART transmitter.
//
// A frame-level model turns each accepted byte into the sequence of line
// levels it must produce (N samples per bit) and is compared against the
// DUT every cycle; directed tests add literal expectations for bit
// patterns, frame length, back-to-back gap and reset behaviour.
// Honours TX_PARITY_EN the same way the design does.
module tb_tx;
  import uart_pkg::*;

  localparam int N = 8;
`ifdef TX_PARITY_EN
  localparam int FB = FRAME_BITS_8E1;
  localparam logic [10:0] EXP_A5 = 11'b10101001010;
  localparam logic [10:0] EXP_81 = 11'b10100000010;
  localparam logic [10:0] EXP_5A = 11'b10010110100;
  localparam logic [10:0] EXP_07 = 11'b11000001110;
  localparam logic [10:0] EXP_03 = 11'b10000000110;
`else
  localparam int FB = FRAME_BITS_8N1;
  localparam logic [10:0] EXP_A5 = 11'b01101001010;
  localparam logic [10:0] EXP_81 = 11'b01100000010;
  localparam logic [10:0] EXP_5A = 11'b01010110100;
  localparam logic [10:0] EXP_07 = 11'b01000001110;
  localparam logic [10:0] EXP_03 = 11'b01000000110;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_ready;
  logic       data_out;
  logic       busy;

  always #5 clk = ~clk;

  tx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_out   (data_out),
    .busy       (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- frame model ----------------
  bit known = 1'b0;
  bit q[$];

  function automatic void push_frame(input logic [7:0] b);
    bit lvl[$];
    lvl.push_back(1'b0);
    for (int i = 0; i < 8; i++) lvl.push_back(b[i]);
`ifdef TX_PARITY_EN
    lvl.push_back(^b);
`endif
    lvl.push_back(1'b1);
    foreach (lvl[k]) for (int s = 0; s < N; s++) q.push_back(lvl[k]);
  endfunction

  always @(posedge clk) begin
    bit exp_line, exp_busy, exp_ready;
    if (rst) begin
      q.delete();
      known = 1'b1;
    end else if (known) begin
      if (q.size() == 0) begin
        if (tx_en && data_valid) push_frame(data_in);
      end else begin
        void'(q.pop_front());
      end
    end
    #1;
    if (known) begin
      exp_line  = (q.size() != 0) ? q[0] : 1'b1;
      exp_busy  = (q.size() != 0);
      exp_ready = (q.size() == 0) && !rst;
      vectors++;
      if (data_out !== exp_line || busy !== exp_busy || data_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL model t=%0t got line=%b busy=%b ready=%b need line=%b busy=%b ready=%b",
                 $time, data_out, busy, data_ready, exp_line, exp_busy, exp_ready);
      end
    end
  end

  // ---------------- busy / gap monitor ----------------
  int busy_run = 0, idle_run = 0, last_busy_len = 0, last_gap = 0;
  always @(negedge clk) begin
    if (known) begin
      if (busy === 1'b1) begin
        if (busy_run == 0) last_gap = idle_run;
        busy_run++;
        idle_run = 0;
      end else begin
        if (busy_run > 0) last_busy_len = busy_run;
        busy_run = 0;
        idle_run++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=0x%0h need=0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (data_ready === 1'b1) return;
    end
    check({name, " ready timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    check({name, " idle timeout"}, 0, 1);
  endtask

  // Send one byte and sample the centre of every bit of its frame. With
  // disturb set, data_in changes and tx_en drops while bit 3 is on the line.
  task automatic send_capture(input logic [7:0] b, input bit disturb,
                              output logic [10:0] got);
    got = '0;
    @(negedge clk);
    data_in = b; tx_en = 1'b1; data_valid = 1'b1;
    wait_ready("send");
    @(posedge clk);
    for (int k = 0; k < FB; k++) begin
      for (int s = 0; s < N; s++) begin
        @(negedge clk);
        if (k == 0 && s == 0) data_valid = 1'b0;
        if (disturb && k == 3 && s == 0) begin
          data_in = ~b; tx_en = 1'b0; data_valid = 1'b1;
        end
        if (s == N / 2) got[k] = data_out;
      end
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [10:0] got;
    int bad;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst data_out", int'(data_out), 1);
    check("rst busy", int'(busy), 0);
    check("rst data_ready", int'(data_ready), 0);
    rst = 1'b0;
    #1 check("ready after rst", int'(data_ready), 1);

    // 0xA5 frame and its length
    send_capture(8'hA5, 1'b0, got);
    check("A5 bits", int'(got), int'(EXP_A5));
    wait_idle("A5");
    repeat (2) @(negedge clk);
    check("A5 busy cycles", last_busy_len, FB * N);

    // Back-to-back 0xFF then 0x00 with data_valid held high
    @(negedge clk);
    data_in = 8'hFF; tx_en = 1'b1; data_valid = 1'b1;
    wait_ready("b2b first");
    @(posedge clk);
    @(negedge clk);
    data_in = 8'h00;
    wait_ready("b2b second");
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    check("b2b idle gap", last_gap, 1);
    wait_idle("b2b");
    repeat (2) @(negedge clk);
    check("b2b second length", last_busy_len, FB * N);

    // data_valid with tx_en low must never start a frame
    tx_en = 1'b0; data_valid = 1'b1; data_in = 8'h55;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || data_out !== 1'b1) bad++;
    end
    check("tx_en low no frame", bad, 0);
    data_valid = 1'b0; tx_en = 1'b1;

    // Reset in the middle of a 0x3C frame, then 0x81 is sent cleanly
    @(negedge clk);
    data_in = 8'h3C; data_valid = 1'b1;
    wait_ready("3C");
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset data_out", int'(data_out), 1);
    check("midreset busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midreset ready", int'(data_ready), 1);
    send_capture(8'h81, 1'b0, got);
    check("81 bits", int'(got), int'(EXP_81));
    wait_idle("81");

    // data_in change and tx_en drop mid-frame of 0x5A
    send_capture(8'h5A, 1'b1, got);
    check("5A bits", int'(got), int'(EXP_5A));
    wait_idle("5A");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check("5A no restart", bad, 0);
    data_valid = 1'b0; tx_en = 1'b1;

    // Parity-sensitive bytes (parity bit present only with TX_PARITY_EN)
    send_capture(8'h07, 1'b0, got);
    check("07 bits", int'(got), int'(EXP_07));
    wait_idle("07");
    repeat (2) @(negedge clk);
    check("07 busy cycles", last_busy_len, FB * N);
    send_capture(8'h03, 1'b0, got);
    check("03 bits", int'(got), int'(EXP_03));
    wait_idle("03");

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
